// File: rtl/load_store_unit.sv
// Load/store unit with an internal word-organised data memory.
// Each request is held in a WAIT phase for LATENCY cycles, then answered for one cycle in DONE.
module load_store_unit #(
   parameter int MEM_DEPTH = 256,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   input  logic [31:0] store_data,
   output logic        resp_valid,
   output logic [31:0] load_data,
   output logic        error,
   output logic        busy
);

   // state  | meaning
   // S_IDLE | ready for a request
   // S_WAIT | legal access in flight, down-counter running
   // S_DONE | one-cycle response (data or error)

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            rd_q;
   logic            wr_q;
   logic [2:0]      f3_q;
   logic [AW+1:0]   addr_q;
   logic [31:0]     sd_q;
   logic            resp_valid_q;
   logic            error_q;
   logic [31:0]     load_data_q;

   logic [31:0]     mem [MEM_DEPTH];

   logic            legal;
   logic            last_wait;
   logic [AW-1:0]   idx;
   logic [31:0]     rd_word;
   logic [31:0]     shifted;
   logic [31:0]     load_data_d;
   logic [31:0]     wdata;
   logic [3:0]      be;

   always_comb begin
      legal = 1'b1;
      if (mem_read == mem_write) legal = 1'b0;
      if (mem_write && funct3[2]) legal = 1'b0;
      case (funct3)
         3'b000, 3'b100: ;
         3'b001, 3'b101: if (address[0]) legal = 1'b0;
         3'b010:         if (address[1:0] != 2'b00) legal = 1'b0;
         default:        legal = 1'b0;
      endcase
   end

   assign last_wait = (state_q == S_WAIT) && (cnt_q == '0);
   assign idx       = addr_q[AW+1:2];
   assign rd_word   = mem[idx];
   assign shifted   = rd_word >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  load_data_d = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data_d = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data_d = {24'h0, shifted[7:0]};
         3'b101:  load_data_d = {16'h0, shifted[15:0]};
         default: load_data_d = shifted;
      endcase
   end

   // Replicate the operand across lanes so the byte enables alone select what lands.
   always_comb begin
      case (f3_q[1:0])
         2'b00: begin
            wdata = {4{sd_q[7:0]}};
            be    = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            wdata = {2{sd_q[15:0]}};
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata = sd_q;
            be    = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset && last_wait && wr_q) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         error_q      <= 1'b0;
         load_data_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               resp_valid_q <= 1'b0;
               error_q      <= 1'b0;
               if (req_valid) begin
                  rd_q   <= mem_read;
                  wr_q   <= mem_write;
                  f3_q   <= funct3;
                  addr_q <= address[AW+1:0];
                  sd_q   <= store_data;
                  if (legal) begin
                     state_q <= S_WAIT;
                     cnt_q   <= CW'(LATENCY - 1);
                  end else begin
                     state_q      <= S_DONE;
                     resp_valid_q <= 1'b1;
                     error_q      <= 1'b1;
                     load_data_q  <= '0;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
                  state_q      <= S_DONE;
                  resp_valid_q <= 1'b1;
                  error_q      <= 1'b0;
                  load_data_q  <= rd_q ? load_data_d : 32'h0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               resp_valid_q <= 1'b0;
               error_q      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign resp_valid = resp_valid_q;
   assign error      = error_q;
   assign load_data  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (MEM_DEPTH=256, LATENCY=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] store_data;
   logic        resp_valid;
   logic [31:0] load_data;
   logic        error;
   logic        busy;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.MEM_DEPTH(256), .LATENCY(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .address    (address),
      .store_data (store_data),
      .resp_valid (resp_valid),
      .load_data  (load_data),
      .error      (error),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one request, scrambles the inputs right after acceptance, and returns
   // the response plus the number of falling edges from acceptance to resp_valid.
   task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         output logic [31:0] ld, output logic er, output int lat);
      @(negedge clk);
      mem_read = rd; mem_write = wr; funct3 = f3; address = a; store_data = sd;
      req_valid = 1'b1;
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      if (!req_ready) chk({tag, "_accept_timeout"}, 32'd1, 32'd0);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      mem_read   = 1'($urandom);
      mem_write  = 1'($urandom);
      funct3     = 3'($urandom);
      address    = $urandom;
      store_data = $urandom;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (resp_valid) break;
      end
      if (!resp_valid) chk({tag, "_resp_timeout"}, 32'd1, 32'd0);
      ld = load_data;
      er = error;
      @(negedge clk);
      chk({tag, "_pulse"}, {31'h0, resp_valid}, 32'd0);
      chk({tag, "_hold"}, load_data, ld);
   endtask

   logic [31:0] ld;
   logic        er;
   int          lat;

   initial begin
      reset = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      funct3 = 3'b000; address = '0; store_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_resp", {31'h0, resp_valid}, 32'd0);
      chk("rst_err", {31'h0, error}, 32'd0);
      chk("rst_ld", load_data, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'h0, req_ready}, 32'd1);

      access("sw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, ld, er, lat);
      chk("sw10_lat", lat, 32'd3);
      chk("sw10_err", {31'h0, er}, 32'd0);
      chk("sw10_ld", ld, 32'h0);

      access("lw10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, ld, er, lat);
      chk("lw10_lat", lat, 32'd3);
      chk("lw10_err", {31'h0, er}, 32'd0);
      chk("lw10_ld", ld, 32'hDEADBEEF);

      access("lb13", 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, ld, er, lat);
      chk("lb13_ld", ld, 32'hFFFFFFDE);
      access("lbu13", 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, ld, er, lat);
      chk("lbu13_ld", ld, 32'h000000DE);
      access("lh12", 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, ld, er, lat);
      chk("lh12_ld", ld, 32'hFFFFDEAD);
      access("lhu12", 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, ld, er, lat);
      chk("lhu12_ld", ld, 32'h0000DEAD);
      access("lbu10", 1'b1, 1'b0, 3'b100, 32'h10, 32'h0, ld, er, lat);
      chk("lbu10_ld", ld, 32'h000000EF);

      access("sb11", 1'b0, 1'b1, 3'b000, 32'h11, 32'hAABBCC55, ld, er, lat);
      access("lw10b", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, ld, er, lat);
      chk("after_sb_ld", ld, 32'hDEAD55EF);
      access("sh12", 1'b0, 1'b1, 3'b001, 32'h12, 32'h99991234, ld, er, lat);
      access("lw10c", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, ld, er, lat);
      chk("after_sh_ld", ld, 32'h123455EF);

      access("ill_lw12", 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, ld, er, lat);
      chk("ill_lw12_lat", lat, 32'd1);
      chk("ill_lw12_err", {31'h0, er}, 32'd1);
      chk("ill_lw12_ld", ld, 32'h0);
      access("ill_sh11", 1'b0, 1'b1, 3'b001, 32'h11, 32'h0000FFFF, ld, er, lat);
      chk("ill_sh11_lat", lat, 32'd1);
      chk("ill_sh11_err", {31'h0, er}, 32'd1);
      access("ill_rw", 1'b1, 1'b1, 3'b010, 32'h10, 32'h00000000, ld, er, lat);
      chk("ill_rw_lat", lat, 32'd1);
      chk("ill_rw_err", {31'h0, er}, 32'd1);
      access("ill_sbu", 1'b0, 1'b1, 3'b100, 32'h10, 32'h00000000, ld, er, lat);
      chk("ill_sbu_err", {31'h0, er}, 32'd1);
      access("lw10d", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, ld, er, lat);
      chk("after_ill_ld", ld, 32'h123455EF);
      chk("after_ill_err", {31'h0, er}, 32'd0);

      // Store aborted by reset in its first wait cycle.
      access("sw20", 1'b0, 1'b1, 3'b010, 32'h20, 32'h01020304, ld, er, lat);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010;
      address = 32'h20; store_data = 32'hCAFEF00D; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort_busy_wait", {31'h0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'h0, busy}, 32'd0);
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
         end
         chk("abort_no_resp", {31'h0, seen}, 32'd0);
      end
      access("lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, ld, er, lat);
      chk("abort_lw20_ld", ld, 32'h01020304);

      // req_valid held high; the follow-up load waits for IDLE and sees the wrapped store.
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010;
      address = 32'h400; store_data = 32'h11111111; req_valid = 1'b1;
      @(posedge clk);
      #1;
      mem_read = 1'b1; mem_write = 1'b0; address = 32'h0; store_data = 32'h0;
      begin
         int n = 0;
         int n1 = 0;
         int n2 = 0;
         for (int i = 0; i < 30 && n2 == 0; i++) begin
            @(negedge clk);
            n++;
            if (resp_valid && n1 == 0) begin
               n1 = n;
               chk("held_sw_err", {31'h0, error}, 32'd0);
               chk("held_sw_ld", load_data, 32'h0);
               chk("held_done_ready", {31'h0, req_ready}, 32'd0);
            end else if (resp_valid) begin
               n2 = n;
               chk("wrap_lw_ld", load_data, 32'h11111111);
            end
         end
         req_valid = 1'b0;
         chk("held_sw_lat", n1, 32'd3);
         chk("held_lw_lat", n2, 32'd7);
      end
      @(negedge clk);
      chk("held_end_pulse", {31'h0, resp_valid}, 32'd0);
      access("lw400", 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, ld, er, lat);
      chk("lw400_ld", ld, 32'h11111111);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 32-bit words in the internal data memory (power of two, minimum 4).
REQ-002 Parameter LATENCY, default 2, number of wait cycles per legal access (minimum 1).
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  unit can accept a request this cycle.
REQ-007 Port mem_read  input  1  request is a load.
REQ-008 Port mem_write  input  1  request is a store.
REQ-009 Port funct3  input  3  access size and sign (000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned).
REQ-010 Port address  input  32  byte address (ALU result).
REQ-011 Port store_data  input  32  store operand (register Data2).
REQ-012 Port resp_valid  output  1  one-cycle response pulse.
REQ-013 Port load_data  output  32  extended load result (write-back data).
REQ-014 Port error  output  1  response is an error; qualified by resp_valid.
REQ-015 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The unit SHALL implement three states, IDLE, WAIT and DONE; req_ready SHALL be 1 only in IDLE.
REQ-017 The unit SHALL accept a request when req_valid and req_ready are both 1, latching mem_read, mem_write, funct3, address and store_data; later changes to these inputs SHALL have no effect on the accepted request.
REQ-018 An accepted request SHALL be illegal when mem_read equals mem_write, when funct3 is 011, 110 or 111, when funct3 is 100 or 101 on a store, when a half access has address[0]=1, or when a word access has address[1:0]!=00.
REQ-019 An illegal request SHALL go IDLE->DONE and perform no memory access, with resp_valid=1, error=1 and load_data=0 in the cycle after acceptance.
REQ-020 A legal request SHALL go IDLE->WAIT; a counter SHALL count LATENCY cycles; WAIT->DONE SHALL occur on the edge that ends the last wait cycle.
REQ-021 An access accepted at edge T SHALL assert resp_valid in the cycle after edge T+LATENCY, with error=0.
REQ-022 Word index SHALL be address[log2(MEM_DEPTH)+1:2]; higher address bits SHALL be ignored, so the address space wraps.
REQ-023 A store SHALL update only the addressed lanes on the WAIT->DONE edge: byte store writes lane address[1:0] from store_data[7:0]; half store writes lanes 1:0 or 3:2 from store_data[15:0]; word store writes all lanes.
REQ-024 A load SHALL read the word on the WAIT->DONE edge, shift right by 8*address[1:0], and sign-extend (000, 001) or zero-extend (100, 101) to 32 bits.
REQ-025 DONE SHALL last exactly one cycle and then go to IDLE; the earliest next acceptance is the cycle after resp_valid.
REQ-026 load_data SHALL hold its last response value until the next response; a store response SHALL drive load_data=0.
REQ-027 Memory lane order SHALL be little-endian: byte address 4k+0 is bits [7:0].

Reset
REQ-028 While reset=1 the unit SHALL go to IDLE and drive counter=0, resp_valid=0, error=0, load_data=0 and busy=0; req_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset during WAIT SHALL abort the request: no memory write and no response.
REQ-030 Reset SHALL NOT clear memory contents.

Verification
REQ-031 LATENCY=2: SW 0xDEADBEEF to 0x10 at edge 0, resp at edge 3; then LW 0x10 -> load_data=0xDEADBEEF, error=0, three cycles after acceptance.
REQ-032 With 0x10=0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
REQ-033 SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF; SH 0x1234 to 0x12, then LW 0x10 -> 0x123455EF.
REQ-034 LW 0x12, SH 0x11, and mem_read=mem_write=1 -> each gives resp_valid with error=1 and load_data=0 one cycle after acceptance, and memory is unchanged.
REQ-035 SW 0xCAFEF00D to 0x20 with reset pulsed in the first WAIT cycle -> no resp_valid; then LW 0x20 returns its prior value.
REQ-036 req_valid held high through WAIT and DONE is not accepted until IDLE; with MEM_DEPTH=256, SW 0x11111111 to 0x400 followed by LW 0x000 -> 0x11111111.
